// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
//
// Shared definitions for the RV32 decode stage: major opcodes, the
// funct3/funct7 values of the supported operations, the immediate-format
// enum and the decoded_t record produced by one lane decoder.
//
// Supported subset:
//   OP      (0110011) : ADD, SUB, XOR, SRA
//   OP-IMM  (0010011) : ADDI, ANDI
//   LOAD    (0000011) : LW
//   STORE   (0100011) : SW
// ---------------------------------------------------------------------------
package decode_pkg;

    // RV32 encodings are always 32 bits wide, independent of the datapath
    // width chosen for the pipe.
    localparam int INSTR_W = 32;

    // Major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRA     = 3'b101;
    localparam logic [2:0] F3_ADDI    = 3'b000;
    localparam logic [2:0] F3_ANDI    = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;

    // funct7 values: BASE for ADD/XOR, ALT for SUB/SRA
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Immediate format of a legal instruction; FMT_NONE marks an illegal one.
    typedef enum logic [1:0] {
        FMT_NONE = 2'd0,
        FMT_R    = 2'd1,
        FMT_I    = 2'd2,
        FMT_S    = 2'd3
    } imm_fmt_e;

    // Result of decoding one instruction.
    typedef struct packed {
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [INSTR_W-1:0] imm;
        logic               use_rs1;
        logic               use_rs2;
        logic               wr_rd;
        logic               illegal;
    } decoded_t;

    // Sign-extend a 12-bit immediate to the instruction width.
    function automatic logic [INSTR_W-1:0] sext12(input logic [11:0] v);
        return {{(INSTR_W-12){v[11]}}, v};
    endfunction

endpackage

// File: rtl/decode_lane.sv
// ---------------------------------------------------------------------------
// decode_lane
//
// Purely combinational decoder for a single RV32 instruction.
//
// Ports:
//   instr  in   32-bit raw instruction
//   dec    out  decoded_t: fields, sign-extended immediate, operand usage,
//               destination write flag and illegal flag
//
// Register fields are always extracted from their fixed bit positions, even
// for illegal encodings, so downstream debug logic can still see them.
// ---------------------------------------------------------------------------
module decode_lane
    import decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decoded_t           dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    imm_fmt_e   fmt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];

    // Classify the encoding. Anything not explicitly listed stays FMT_NONE
    // and is therefore reported as illegal.
    always_comb begin
        fmt = FMT_NONE;
        case (opcode)
            OPC_OP: begin
                if ((funct3 == F3_ADD_SUB && (funct7 == F7_BASE || funct7 == F7_ALT)) ||
                    (funct3 == F3_XOR     &&  funct7 == F7_BASE) ||
                    (funct3 == F3_SRA     &&  funct7 == F7_ALT)) begin
                    fmt = FMT_R;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == F3_ADDI || funct3 == F3_ANDI) begin
                    fmt = FMT_I;
                end
            end
            OPC_LOAD: begin
                if (funct3 == F3_LW) begin
                    fmt = FMT_I;
                end
            end
            OPC_STORE: begin
                if (funct3 == F3_SW) begin
                    fmt = FMT_S;
                end
            end
            default: fmt = FMT_NONE;
        endcase
    end

    // Build the decoded record. Raw fields are always passed through; the
    // immediate and usage flags depend on the format, and an illegal
    // encoding keeps them all at zero so rename never allocates for it.
    always_comb begin
        dec         = '0;
        dec.opcode  = opcode;
        dec.funct3  = funct3;
        dec.funct7  = funct7;
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.rd      = rd;
        case (fmt)
            FMT_R: begin
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.wr_rd   = (rd != 5'd0);
            end
            FMT_I: begin
                dec.use_rs1 = 1'b1;
                dec.wr_rd   = (rd != 5'd0);
                dec.imm     = sext12(instr[31:20]);
            end
            FMT_S: begin
                dec.use_rs1 = 1'b1;
                dec.use_rs2 = 1'b1;
                dec.imm     = sext12({instr[31:25], instr[11:7]});
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_pipe.sv
// ---------------------------------------------------------------------------
// decode_pipe
//
// Registered N-wide decode stage between fetch and rename/dispatch.
//
// Parameters:
//   N      lanes per bundle (1..4)
//   XLEN   instruction / immediate / PC width (>= 32)
//   SEQ_W  sequence number width
//
// Ports:
//   clk, rst_n       clock (rising edge), synchronous active-low reset
//   flush            drop the held bundle and the one offered this cycle
//   in_valid[N]      per-lane instruction present
//   in_instr, in_pc  lane i at [i*XLEN +: XLEN]
//   in_ready         stage can take a bundle this cycle
//   out_valid        registered bundle present
//   out_lane_valid   per-lane valid of the registered bundle
//   out_ready        consumer takes the bundle this cycle
//   out_opcode/funct3/funct7/rs1/rs2/rd/imm   decoded fields per lane
//   out_use_rs1/use_rs2/wr_rd/illegal         usage and legality per lane
//   out_pc, out_seq  passthrough PC and wrapping sequence number per lane
//
// A bundle accepted on edge k is visible right after edge k. The output
// register holds under back-pressure; a consume and a new accept on the
// same edge simply overwrite it, so back-to-back flow has no bubbles.
// ---------------------------------------------------------------------------
module decode_pipe
    import decode_pkg::*;
#(
    parameter int N     = 2,
    parameter int XLEN  = 32,
    parameter int SEQ_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [N-1:0]         in_valid,
    input  logic [N*XLEN-1:0]    in_instr,
    input  logic [N*XLEN-1:0]    in_pc,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [N-1:0]         out_lane_valid,
    input  logic                 out_ready,
    output logic [N*7-1:0]       out_opcode,
    output logic [N*3-1:0]       out_funct3,
    output logic [N*7-1:0]       out_funct7,
    output logic [N*5-1:0]       out_rs1,
    output logic [N*5-1:0]       out_rs2,
    output logic [N*5-1:0]       out_rd,
    output logic [N*XLEN-1:0]    out_imm,
    output logic [N-1:0]         out_use_rs1,
    output logic [N-1:0]         out_use_rs2,
    output logic [N-1:0]         out_wr_rd,
    output logic [N-1:0]         out_illegal,
    output logic [N*XLEN-1:0]    out_pc,
    output logic [N*SEQ_W-1:0]   out_seq
);

    decoded_t            lane_dec [N];
    logic [SEQ_W-1:0]    seq_ctr;
    logic [SEQ_W-1:0]    seq_sum;
    logic                accept;

    logic [N-1:0]        nxt_lane_valid;
    logic [N*7-1:0]      nxt_opcode;
    logic [N*3-1:0]      nxt_funct3;
    logic [N*7-1:0]      nxt_funct7;
    logic [N*5-1:0]      nxt_rs1;
    logic [N*5-1:0]      nxt_rs2;
    logic [N*5-1:0]      nxt_rd;
    logic [N*XLEN-1:0]   nxt_imm;
    logic [N-1:0]        nxt_use_rs1;
    logic [N-1:0]        nxt_use_rs2;
    logic [N-1:0]        nxt_wr_rd;
    logic [N-1:0]        nxt_illegal;
    logic [N*XLEN-1:0]   nxt_pc;
    logic [N*SEQ_W-1:0]  nxt_seq;

    // One combinational decoder per lane; only the low 32 bits of each
    // lane slot carry the instruction encoding.
    for (genvar g = 0; g < N; g++) begin : g_lane
        decode_lane u_lane (
            .instr (in_instr[g*XLEN +: INSTR_W]),
            .dec   (lane_dec[g])
        );
    end

    // The register can be refilled whenever it is empty or being drained
    // this cycle. An empty bundle is never taken, and flush blocks loading.
    assign in_ready = !out_valid || out_ready;
    assign accept   = (|in_valid) && in_ready && !flush;

    // Assemble the next register contents. Invalid lanes are forced to all
    // zero. Sequence numbers come from a running count of valid lanes below
    // each lane, so gaps in in_valid do not consume numbers; the final
    // count is the counter advance. SEQ_W-bit arithmetic gives the wrap.
    always_comb begin
        logic [SEQ_W-1:0] cnt;
        cnt            = '0;
        nxt_lane_valid = '0;
        nxt_opcode     = '0;
        nxt_funct3     = '0;
        nxt_funct7     = '0;
        nxt_rs1        = '0;
        nxt_rs2        = '0;
        nxt_rd         = '0;
        nxt_imm        = '0;
        nxt_use_rs1    = '0;
        nxt_use_rs2    = '0;
        nxt_wr_rd      = '0;
        nxt_illegal    = '0;
        nxt_pc         = '0;
        nxt_seq        = '0;
        for (int i = 0; i < N; i++) begin
            if (in_valid[i]) begin
                nxt_lane_valid[i]            = 1'b1;
                nxt_opcode[i*7 +: 7]         = lane_dec[i].opcode;
                nxt_funct3[i*3 +: 3]         = lane_dec[i].funct3;
                nxt_funct7[i*7 +: 7]         = lane_dec[i].funct7;
                nxt_rs1[i*5 +: 5]            = lane_dec[i].rs1;
                nxt_rs2[i*5 +: 5]            = lane_dec[i].rs2;
                nxt_rd[i*5 +: 5]             = lane_dec[i].rd;
                nxt_imm[i*XLEN +: XLEN]      = XLEN'(signed'(lane_dec[i].imm));
                nxt_use_rs1[i]               = lane_dec[i].use_rs1;
                nxt_use_rs2[i]               = lane_dec[i].use_rs2;
                nxt_wr_rd[i]                 = lane_dec[i].wr_rd;
                nxt_illegal[i]               = lane_dec[i].illegal;
                nxt_pc[i*XLEN +: XLEN]       = in_pc[i*XLEN +: XLEN];
                nxt_seq[i*SEQ_W +: SEQ_W]    = seq_ctr + cnt;
                cnt                          = cnt + SEQ_W'(1);
            end
        end
        seq_sum = cnt;
    end

    // Pipeline register and sequence counter. Priority is reset, then
    // flush (which wins over any accept or handshake and leaves the counter
    // alone), then loading a new bundle, then draining to empty. Data
    // fields are left untouched on flush/drain; only the valids drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_lane_valid <= '0;
            out_opcode     <= '0;
            out_funct3     <= '0;
            out_funct7     <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_rd         <= '0;
            out_imm        <= '0;
            out_use_rs1    <= '0;
            out_use_rs2    <= '0;
            out_wr_rd      <= '0;
            out_illegal    <= '0;
            out_pc         <= '0;
            out_seq        <= '0;
            seq_ctr        <= '0;
        end else if (flush) begin
            out_valid      <= 1'b0;
            out_lane_valid <= '0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_lane_valid <= nxt_lane_valid;
            out_opcode     <= nxt_opcode;
            out_funct3     <= nxt_funct3;
            out_funct7     <= nxt_funct7;
            out_rs1        <= nxt_rs1;
            out_rs2        <= nxt_rs2;
            out_rd         <= nxt_rd;
            out_imm        <= nxt_imm;
            out_use_rs1    <= nxt_use_rs1;
            out_use_rs2    <= nxt_use_rs2;
            out_wr_rd      <= nxt_wr_rd;
            out_illegal    <= nxt_illegal;
            out_pc         <= nxt_pc;
            out_seq        <= nxt_seq;
            seq_ctr        <= seq_ctr + seq_sum;
        end else if (out_ready) begin
            out_valid      <= 1'b0;
            out_lane_valid <= '0;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_decode_pipe
//
// Directed bench for decode_pipe with N=2, XLEN=32 and SEQ_W=3 so that the
// sequence counter wraps within a short run. Stimulus pushes the expected
// bundle into a scoreboard queue when it is accepted; a monitor pops and
// compares whenever the DUT hands a bundle to the consumer.
// ---------------------------------------------------------------------------
module tb_decode_pipe;

    localparam int N     = 2;
    localparam int XLEN  = 32;
    localparam int SEQ_W = 3;

    // Instructions under test
    localparam logic [31:0] I_ADD  = 32'h002081B3;  // ADD  x3,x1,x2
    localparam logic [31:0] I_ADDI = 32'hFFF00293;  // ADDI x5,x0,-1
    localparam logic [31:0] I_SW   = 32'h0020A423;  // SW   x2,8(x1)
    localparam logic [31:0] I_LW   = 32'hFFC0A203;  // LW   x4,-4(x1)
    localparam logic [31:0] I_SUB  = 32'h406283B3;  // SUB  x7,x5,x6
    localparam logic [31:0] I_XOR  = 32'h003140B3;  // XOR  x1,x2,x3
    localparam logic [31:0] I_SRA  = 32'h40C5D533;  // SRA  x10,x11,x12
    localparam logic [31:0] I_ANDI = 32'h07F0F013;  // ANDI x0,x1,0x7F
    localparam logic [31:0] I_BAD  = 32'h0000007F;  // unknown opcode
    localparam logic [31:0] I_MUL  = 32'h022081B3;  // funct7=0000001
    localparam logic [31:0] I_SLL  = 32'h002091B3;  // funct3=001

    // Hand-computed expectations: {imm, use_rs1, use_rs2, wr_rd, illegal}
    localparam logic [35:0] X_R    = {32'h00000000, 4'b1110};
    localparam logic [35:0] X_ADDI = {32'hFFFFFFFF, 4'b1010};
    localparam logic [35:0] X_SW   = {32'h00000008, 4'b1100};
    localparam logic [35:0] X_LW   = {32'hFFFFFFFC, 4'b1010};
    localparam logic [35:0] X_ANDI = {32'h0000007F, 4'b1000};
    localparam logic [35:0] X_ILL  = {32'h00000000, 4'b0001};

    typedef struct packed {
        logic             lv;
        logic [6:0]       op;
        logic [2:0]       f3;
        logic [6:0]       f7;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [31:0]      imm;
        logic             u1;
        logic             u2;
        logic             wr;
        logic             ill;
        logic [31:0]      pc;
        logic [SEQ_W-1:0] seq;
    } lane_exp_t;

    typedef lane_exp_t [N-1:0] bundle_t;

    logic                 clk;
    logic                 rst_n;
    logic                 flush;
    logic [N-1:0]         in_valid;
    logic [N*XLEN-1:0]    in_instr;
    logic [N*XLEN-1:0]    in_pc;
    logic                 in_ready;
    logic                 out_valid;
    logic [N-1:0]         out_lane_valid;
    logic                 out_ready;
    logic [N*7-1:0]       out_opcode;
    logic [N*3-1:0]       out_funct3;
    logic [N*7-1:0]       out_funct7;
    logic [N*5-1:0]       out_rs1;
    logic [N*5-1:0]       out_rs2;
    logic [N*5-1:0]       out_rd;
    logic [N*XLEN-1:0]    out_imm;
    logic [N-1:0]         out_use_rs1;
    logic [N-1:0]         out_use_rs2;
    logic [N-1:0]         out_wr_rd;
    logic [N-1:0]         out_illegal;
    logic [N*XLEN-1:0]    out_pc;
    logic [N*SEQ_W-1:0]   out_seq;

    bundle_t              sb_q [$];
    bundle_t              mon_e;
    int                   total = 0;
    int                   bad   = 0;
    logic                 exp_valid;
    logic [SEQ_W-1:0]     exp_ctr;
    logic [31:0]          pc_base;
    logic [511:0]         snap;

    decode_pipe #(
        .N     (N),
        .XLEN  (XLEN),
        .SEQ_W (SEQ_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_lane_valid (out_lane_valid),
        .out_ready      (out_ready),
        .out_opcode     (out_opcode),
        .out_funct3     (out_funct3),
        .out_funct7     (out_funct7),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_rd         (out_rd),
        .out_imm        (out_imm),
        .out_use_rs1    (out_use_rs1),
        .out_use_rs2    (out_use_rs2),
        .out_wr_rd      (out_wr_rd),
        .out_illegal    (out_illegal),
        .out_pc         (out_pc),
        .out_seq        (out_seq)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Every DUT output flattened into one vector for hold/reset checks.
    function automatic logic [511:0] outs();
        return 512'({out_valid, out_lane_valid, out_opcode, out_funct3, out_funct7,
                     out_rs1, out_rs2, out_rd, out_imm, out_use_rs1, out_use_rs2,
                     out_wr_rd, out_illegal, out_pc, out_seq});
    endfunction

    task automatic checkWide(input string name, input logic [511:0] act, input logic [511:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Expected lane: raw fields sliced from the encoding, the rest from the
    // hand-computed table; an invalid lane is expected to be all zero.
    function automatic lane_exp_t mk(input logic v, input logic [31:0] ins, input logic [35:0] x,
                                     input logic [31:0] pc, input logic [SEQ_W-1:0] seq);
        lane_exp_t e;
        e = '0;
        if (v) begin
            e.lv  = 1'b1;
            e.op  = ins[6:0];
            e.rd  = ins[11:7];
            e.f3  = ins[14:12];
            e.rs1 = ins[19:15];
            e.rs2 = ins[24:20];
            e.f7  = ins[31:25];
            e.imm = x[35:4];
            e.u1  = x[3];
            e.u2  = x[2];
            e.wr  = x[1];
            e.ill = x[0];
            e.pc  = pc;
            e.seq = seq;
        end
        return e;
    endfunction

    // Drive one cycle of inputs, update the reference model of the stage
    // (occupancy, counter, scoreboard) and check handshake signals.
    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] i0, input logic [35:0] x0,
                                 input logic [31:0] i1, input logic [35:0] x1,
                                 input logic ordy, input logic fl, input logic rn);
        bundle_t          b;
        logic [SEQ_W-1:0] s;
        logic             acc;
        in_valid  = v;
        in_instr  = {i1, i0};
        in_pc     = {pc_base + 32'd4, pc_base};
        out_ready = ordy;
        flush     = fl;
        rst_n     = rn;
        #1;
        checkOutput("in_ready", 64'(in_ready), 64'(!exp_valid || ordy));
        if (!rn) begin
            sb_q.delete();
            exp_valid = 1'b0;
            exp_ctr   = '0;
        end else if (fl) begin
            if (exp_valid) sb_q.delete(0);
            exp_valid = 1'b0;
        end else begin
            acc = (|v) && (!exp_valid || ordy);
            if (acc) begin
                s    = exp_ctr;
                b[0] = mk(v[0], i0, x0, pc_base, s);
                if (v[0]) s = s + SEQ_W'(1);
                b[1] = mk(v[1], i1, x1, pc_base + 32'd4, s);
                if (v[1]) s = s + SEQ_W'(1);
                exp_ctr = s;
                sb_q.push_back(b);
                exp_valid = 1'b1;
            end else if (ordy) begin
                exp_valid = 1'b0;
            end
        end
        pc_base = pc_base + 32'd8;
        @(posedge clk);
        #1;
        checkOutput("out_valid", 64'(out_valid), 64'(exp_valid));
    endtask

    // Monitor: whenever the consumer takes a bundle, compare it with the
    // oldest expected bundle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush === 1'b0) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected bundle: got seq %0h required none", out_seq);
            end else begin
                mon_e = sb_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    checkOutput($sformatf("lane%0d valid", i), 64'(out_lane_valid[i]), 64'(mon_e[i].lv));
                    checkOutput($sformatf("lane%0d fields", i),
                                64'({out_opcode[i*7 +: 7], out_funct3[i*3 +: 3], out_funct7[i*7 +: 7],
                                     out_rs1[i*5 +: 5], out_rs2[i*5 +: 5], out_rd[i*5 +: 5]}),
                                64'({mon_e[i].op, mon_e[i].f3, mon_e[i].f7,
                                     mon_e[i].rs1, mon_e[i].rs2, mon_e[i].rd}));
                    checkOutput($sformatf("lane%0d imm", i), 64'(out_imm[i*XLEN +: XLEN]), 64'(mon_e[i].imm));
                    checkOutput($sformatf("lane%0d flags", i),
                                64'({out_use_rs1[i], out_use_rs2[i], out_wr_rd[i], out_illegal[i]}),
                                64'({mon_e[i].u1, mon_e[i].u2, mon_e[i].wr, mon_e[i].ill}));
                    checkOutput($sformatf("lane%0d pc", i), 64'(out_pc[i*XLEN +: XLEN]), 64'(mon_e[i].pc));
                    checkOutput($sformatf("lane%0d seq", i), 64'(out_seq[i*SEQ_W +: SEQ_W]), 64'(mon_e[i].seq));
                end
            end
        end
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = '0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        exp_valid = 1'b0;
        exp_ctr   = '0;
        pc_base   = 32'h0000_1000;

        // Reset: everything zero, ready afterwards
        applyStimulus(2'b00, I_ADD, X_R, I_ADD, X_R, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b00, I_ADD, X_R, I_ADD, X_R, 1'b1, 1'b0, 1'b0);
        checkWide("reset outputs", outs(), '0);

        // Basic flow: ADD/ADDI, then SW/LW, then SUB/XOR
        applyStimulus(2'b11, I_ADD, X_R,    I_ADDI, X_ADDI, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b11, I_SW,  X_SW,   I_LW,   X_LW,   1'b1, 1'b0, 1'b1);
        applyStimulus(2'b11, I_SUB, X_R,    I_XOR,  X_R,    1'b1, 1'b0, 1'b1);

        // Back-pressure: three cycles held while a new bundle is offered
        snap = outs();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, I_SRA, X_R, I_ANDI, X_ANDI, 1'b0, 1'b0, 1'b1);
            checkWide("hold stable", outs(), snap);
        end
        // Release: held bundle drained and the offered one taken (seq 6,7)
        applyStimulus(2'b11, I_SRA, X_R, I_ANDI, X_ANDI, 1'b1, 1'b0, 1'b1);

        // Sparse bundle: lane0 invalid, lane1 illegal opcode (seq 0)
        applyStimulus(2'b10, I_ADD, X_R, I_BAD, X_ILL, 1'b1, 1'b0, 1'b1);
        // Illegal funct7 / funct3 combinations (seq 1,2)
        applyStimulus(2'b11, I_MUL, X_ILL, I_SLL, X_ILL, 1'b1, 1'b0, 1'b1);
        // Single-lane bundles walk the counter to 7
        applyStimulus(2'b01, I_ADD,  X_R,    I_ADDI, X_ADDI, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b11, I_ADDI, X_ADDI, I_LW,   X_LW,   1'b1, 1'b0, 1'b1);
        applyStimulus(2'b01, I_XOR,  X_R,    I_SUB,  X_R,    1'b1, 1'b0, 1'b1);
        // Wrap inside a bundle: seq 7 and 0
        applyStimulus(2'b11, I_SRA, X_R, I_SW, X_SW, 1'b1, 1'b0, 1'b1);
        // Empty offers are never accepted; the stage drains
        applyStimulus(2'b00, I_ADD, X_R, I_ADD, X_R, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b00, I_ADD, X_R, I_ADD, X_R, 1'b1, 1'b0, 1'b1);

        // Flush with a held bundle and a new offer; counter must not move
        applyStimulus(2'b11, I_ADD, X_R, I_ADDI, X_ADDI, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b11, I_SUB, X_R, I_XOR,  X_R,    1'b0, 1'b0, 1'b1);
        applyStimulus(2'b11, I_SUB, X_R, I_XOR,  X_R,    1'b0, 1'b1, 1'b1);
        applyStimulus(2'b11, I_SUB, X_R, I_XOR,  X_R,    1'b1, 1'b0, 1'b1);

        // Reset in the middle of a hold
        applyStimulus(2'b11, I_SRA, X_R, I_ANDI, X_ANDI, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b11, I_SRA, X_R, I_ANDI, X_ANDI, 1'b0, 1'b0, 1'b0);
        checkWide("mid reset outputs", outs(), '0);
        applyStimulus(2'b11, I_ADD, X_R, I_ADDI, X_ADDI, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b00, I_ADD, X_R, I_ADD,  X_R,    1'b1, 1'b0, 1'b1);

        checkOutput("scoreboard drained", 64'(sb_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised, registered N-wide decode stage for the RV32 out-of-order core, sitting between fetch and rename/dispatch. Each cycle it accepts a bundle of up to `N` instructions under a valid/ready handshake. It splits each instruction into fields, generates sign-extended immediates, classifies register usage, flags illegal encodings and stamps a wrapping sequence number. The registered result holds under back-pressure and is dropped on flush.

## Interface
- `N`, 2, lanes per bundle (1..4)
- `XLEN`, 32, instruction/immediate/PC width
- `SEQ_W`, 6, sequence-number width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `flush`  in  1  discard the held bundle and the bundle offered this cycle
- `in_valid`  in  N  per-lane instruction present
- `in_instr`  in  N*XLEN  lane i at bits [i*XLEN +: XLEN]
- `in_pc`  in  N*XLEN  per-lane PC
- `in_ready`  out  1  stage can accept a bundle this cycle
- `out_valid`  out  1  registered bundle present (some lane valid)
- `out_lane_valid`  out  N  per-lane valid
- `out_ready`  in  1  consumer takes the bundle this cycle
- `out_opcode`/`out_funct3`/`out_funct7`  out  N*7/N*3/N*7  fields
- `out_rs1`/`out_rs2`/`out_rd`  out  N*5 each  register indices
- `out_imm`  out  N*XLEN  sign-extended immediate
- `out_use_rs1`/`out_use_rs2`/`out_wr_rd`  out  N each  operand/destination usage
- `out_illegal`  out  N  unsupported encoding
- `out_pc`  out  N*XLEN  passthrough PC
- `out_seq`  out  N*SEQ_W  per-lane sequence number

## Operation
- Supported ops: ADD, SUB, XOR, SRA (opcode 0110011, R-type); ADDI, ANDI (0010011, I); LW (0000011, I); SW (0100011, S).
- R-type: use_rs1=use_rs2=1, imm=0. I-type: use_rs1=1, imm=sext(instr[31:20]). S-type: use_rs1=use_rs2=1, wr_rd=0, imm=sext({instr[31:25],instr[11:7]}).
- wr_rd=1 only for legal R/I ops with rd≠0.
- Illegal = opcode outside the set, or funct3/funct7 combination outside the list above. Illegal lanes: fields still decoded, imm=0, use_*=0, wr_rd=0, illegal=1.
- Invalid lanes (in_valid[i]=0) register all fields, pc and seq as 0.
- Accept = `|in_valid && in_ready && !flush`. An all-zero `in_valid` is never accepted.
- Sequence counter `seq_ctr` (SEQ_W bits). Lane i gets `seq_ctr + popcount(in_valid[i-1:0])`. On accept, `seq_ctr += popcount(in_valid)` mod 2^SEQ_W. Flush does not alter `seq_ctr`.

## Timing
- Latency 1 cycle: accepted at edge k, visible on outputs after edge k.
- `in_ready = !out_valid || out_ready` (combinational, no bubble on back-to-back flow).
- Hold: `out_valid && !out_ready` → all outputs stable.
- Flush: `out_valid` = 0 after the edge. The offered bundle is not accepted and `seq_ctr` is unchanged. Flush wins over a simultaneous accept or handshake.
- Simultaneous consume and accept: new bundle replaces old in the same edge.
- Reset (`!rst_n` at edge): every output register is 0, `out_valid`=0, `seq_ctr`=0. Mid-operation reset discards the held bundle. `in_ready` = 1 once out of reset.
- Counter wrap: seq values wrap modulo 2^SEQ_W within a bundle and across bundles.

## Structure
- `decode_pkg`: opcode/funct3/funct7 localparams, imm-format enum (R/I/S/NONE), `decoded_t` struct (fields, imm, use/wr flags, illegal).
- Sub-module `decode_lane`: combinational single-instruction decoder, instantiated N times via generate. `decode_pipe` owns the handshake, pipeline register, popcount and `seq_ctr`.

## Test plan
- Reset, then N=2 bundle {0x002081B3 ADD x3,x1,x2; 0xFFF00293 ADDI x5,x0,-1}, both valid → next cycle lane0 rs1=1 rs2=2 rd=3 wr_rd=1 imm=0 seq=0; lane1 rd=5 imm=0xFFFFFFFF use_rs2=0 seq=1; seq_ctr=2.
- Lane0 0x0020A423 (SW x2,8(x1)), lane1 0xFFC0A203 (LW x4,-4(x1)) → lane0 imm=8 wr_rd=0 use_rs2=1; lane1 imm=0xFFFFFFFC rd=4 wr_rd=1.
- out_ready=0 for 3 cycles with new bundles offered → in_ready=0, outputs unchanged, seq_ctr unchanged; release → held bundle consumed, next one accepted same edge.
- in_valid=2'b10, instr 0x0000007F → lane0 all zero; lane1 illegal=1, wr_rd=0, seq=seq_ctr; seq_ctr+1.
- SEQ_W=3, seq_ctr=7, full bundle → seq 7 and 0; counter becomes 1.
- Flush with held bundle and new bundle offered → out_valid=0 next cycle, seq_ctr unchanged. Repeat with rst_n=0 mid-hold → all outputs 0, seq_ctr=0.
